// File: rtl/mips86_pkg.sv
// Shared definitions for the mips86 front end: fetch FSM states, instruction
// classes and the major-opcode ranges that have no implementation.
package mips86_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_HOLD       = 3'd4,
    ST_DRAIN      = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    CLASS_R = 2'd0,
    CLASS_I = 2'd1,
    CLASS_J = 2'd2
  } instr_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_ANDI    = 6'd12;
  localparam logic [5:0] OP_ORI     = 6'd13;
  localparam logic [5:0] OP_XORI    = 6'd14;

  localparam logic [5:0] ILLEGAL_LO_MIN = 6'd16;
  localparam logic [5:0] ILLEGAL_LO_MAX = 6'd31;
  localparam logic [5:0] ILLEGAL_HI_MIN = 6'd48;

  function automatic logic is_illegal_op(input logic [5:0] op);
    return ((op >= ILLEGAL_LO_MIN) && (op <= ILLEGAL_LO_MAX)) || (op >= ILLEGAL_HI_MIN);
  endfunction

endpackage

// File: rtl/opcode_field_decoder.sv
// Purely combinational split of a 32-bit opcode into class, register fields,
// extended immediate, jump target and an unsupported-opcode flag.
module opcode_field_decoder
  import mips86_pkg::*;
(
  input  logic [31:0] opcode,
  output logic [1:0]  op_class,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm,
  output logic [25:0] target,
  output logic        illegal
);

  logic [5:0] major;

  always_comb begin
    major  = opcode[31:26];
    rs     = opcode[25:21];
    rt     = opcode[20:16];
    rd     = opcode[15:11];
    shamt  = opcode[10:6];
    funct  = opcode[5:0];
    target = opcode[25:0];

    if (major == OP_SPECIAL) begin
      op_class = CLASS_R;
    end else if ((major == OP_J) || (major == OP_JAL)) begin
      op_class = CLASS_J;
    end else begin
      op_class = CLASS_I;
    end

    // Logical immediates are unsigned; everything else sign-extends.
    if ((major == OP_ANDI) || (major == OP_ORI) || (major == OP_XORI)) begin
      imm = {16'h0000, opcode[15:0]};
    end else begin
      imm = {{16{opcode[15]}}, opcode[15:0]};
    end

    illegal = is_illegal_op(major);
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: launches one opcode-buffer fetch at a time, decodes the
// result into a held output slot, and honours branch redirects at any time.
//
// Handshake: the held instruction transfers on a clock edge where out_valid
// and out_ready are both 1; out_* stay stable while out_valid=1 and
// out_ready=0. A redirect on the same edge wins and drops the instruction.
module fetch_decode_stage
  import mips86_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         WORD_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_IP      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_busy,
  input  logic [WORD_WIDTH-1:0]    fetch_opcode,
  output logic                     start_loading,
  output logic [ADDRESS_WIDTH-1:0] ip,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [WORD_WIDTH-1:0]    out_opcode,
  output logic [1:0]               out_class,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [31:0]              out_imm,
  output logic [25:0]              out_target,
  output logic                     out_illegal,
  output fetch_state_e             state_dbg
);

  fetch_state_e state, state_next;
  logic         capture;

  logic [1:0]  dec_class;
  logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [5:0]  dec_funct;
  logic [31:0] dec_imm;
  logic [25:0] dec_target;
  logic        dec_illegal;

  opcode_field_decoder u_decoder (
    .opcode   (fetch_opcode[31:0]),
    .op_class (dec_class),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .rd       (dec_rd),
    .shamt    (dec_shamt),
    .funct    (dec_funct),
    .imm      (dec_imm),
    .target   (dec_target),
    .illegal  (dec_illegal)
  );

  assign capture   = (state == ST_WAIT_DONE) && !fetch_busy;
  assign state_dbg = state;

  // A redirect in LAUNCH suppresses the pulse so the buffer never starts a
  // fetch from the stale ip; the pulse is reissued next cycle from the new ip.
  assign start_loading = (state == ST_LAUNCH) && !redirect_valid && !reset;

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      case (state)
        ST_WAIT_START, ST_WAIT_DONE, ST_DRAIN: state_next = ST_DRAIN;
        default:                               state_next = ST_LAUNCH;
      endcase
    end else begin
      case (state)
        ST_IDLE:       state_next = ST_LAUNCH;
        ST_LAUNCH:     state_next = ST_WAIT_START;
        ST_WAIT_START: if (fetch_busy)  state_next = ST_WAIT_DONE;
        ST_WAIT_DONE:  if (!fetch_busy) state_next = ST_HOLD;
        ST_HOLD:       if (out_ready)   state_next = ST_LAUNCH;
        ST_DRAIN:      if (!fetch_busy) state_next = ST_LAUNCH;
        default:       state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ip          <= RESET_IP;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_class   <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_shamt   <= '0;
      out_funct   <= '0;
      out_imm     <= '0;
      out_target  <= '0;
      out_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        ip        <= redirect_target & ~ADDRESS_WIDTH'(3);
        out_valid <= 1'b0;
      end else if (capture) begin
        ip          <= ip + ADDRESS_WIDTH'(4);
        out_valid   <= 1'b1;
        out_pc      <= ip;
        out_opcode  <= fetch_opcode;
        out_class   <= dec_class;
        out_rs      <= dec_rs;
        out_rt      <= dec_rt;
        out_rd      <= dec_rd;
        out_shamt   <= dec_shamt;
        out_funct   <= dec_funct;
        out_imm     <= dec_imm;
        out_target  <= dec_target;
        out_illegal <= dec_illegal;
      end else if ((state == ST_HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
